out_wr_dma: RTL and testbench
=============================

// Module: out_wr_dma
// PURPOSE
//  Parametrised successor of the output write DMA. Streams quantized INT8 results from the output
//  accumulator DMA port to DDR over AXI4 in up to MAX_BURST-beat INCR bursts, split at 4 KB
//  boundaries. Read prefetch overlaps AW/W via a credit-gated FIFO. Checks BRESP, rejects
//  misaligned dst_addr, reports err. Sits between output accumulator and AXI write interconnect.
// PARAMETERS
//  AXI_ADDR_W   32   AXI address width
//  AXI_DATA_W   64   AXI/accum data width; BPW = AXI_DATA_W/8 INT8 results per word
//  AXI_ID_W     4    AXI ID width
//  BRAM_ADDR_W  10   accumulator read address width
//  NUM_ACCS     196  results per transfer; NUM_WORDS = ceil(NUM_ACCS/BPW), last word zero-padded by source
//  MAX_BURST    16   max beats per burst (1..256)
//  FIFO_DEPTH   8    prefetch FIFO depth (power of 2, >= RD_LAT+1)
//  RD_LAT       2    accumulator read latency, cycles
//  STREAM_ID    2    AWID value
// PORTS
//  clk            in   1           clock
//  rst_n          in   1           synchronous active-low reset
//  start          in   1           transfer trigger (from sched_done)
//  dst_addr       in   AXI_ADDR_W  DDR destination, sampled on accepted start
//  done           out  1           1-cycle completion pulse
//  err            out  1           valid with done: misaligned addr or BRESP != OKAY
//  busy           out  1           transfer in progress
//  accum_rd_en    out  1           accumulator read strobe
//  accum_rd_addr  out  BRAM_ADDR_W word_index*BPW
//  accum_rd_data  in   AXI_DATA_W  read data, RD_LAT cycles after accum_rd_en
//  accum_ready    in   1           inactive bank ready
//  m_axi_aw*      out/in  std      awid, awaddr, awlen[7:0], awsize=log2(BPW), awburst=INCR, awvalid/awready
//  m_axi_w*       out/in  std      wdata, wstrb all ones, wlast, wvalid/wready
//  m_axi_b*       in/out  std      bid (unused), bresp[1:0], bvalid/bready
// BEHAVIOUR
//  - Reset: every output and all state/counters/FIFO pointers 0; FSM IDLE. Applies mid-transfer; no AXI completion attempted.
//  - IDLE: on start: dst_addr==0 -> done=1, err=0 next cycle, no traffic. dst_addr[log2(BPW)-1:0]!=0 -> done=1, err=1, no traffic.
//    Otherwise latch address, busy=1 -> WAIT_READY. start ignored while busy.
//  - WAIT_READY: on accum_ready, arm read engine (rd_idx=0) -> AW.
//  - Read engine (concurrent): issues accum_rd_en when rd_idx<NUM_WORDS && fifo_count+inflight<FIFO_DEPTH.
//    Shift register of RD_LAT tracks inflight; matching data pushed to FIFO. FIFO never overflows.
//  - AW: len = min(MAX_BURST, words_left, (4096-addr[11:0])/BPW); awlen=len-1.
//    awvalid held until awready; then -> W.
//  - W: wvalid = FIFO non-empty; wdata = FIFO head (show-ahead); pop on wvalid&&wready.
//    wlast on beat len-1. Last beat -> B with bready=1.
//  - B: on bvalid: bresp!=2'b00 -> sticky err, go DRAIN.
//    Else addr += len*BPW, words_left -= len; words_left==0 -> DONE, else -> AW.
//  - DRAIN: stop new reads, wait inflight==0, flush FIFO -> DONE.
//  - DONE: done=1 for one cycle, busy=0 -> IDLE.
//  - AXI: VALID never drops before handshake; awaddr/awlen stable while awvalid.
//    Exactly one burst outstanding.
//  - Counters sized $clog2(NUM_WORDS+1); address arithmetic AXI_ADDR_W wide, wraps modulo 2^AXI_ADDR_W.
//  - Throughput: wready=1 steady state = 1 beat/cycle after FIFO fills; AW/B overhead per burst.
// STRUCTURE
//  - dma_pkg: dma_wr_state_t (IDLE, WAIT_READY, AW, W, B, DRAIN, DONE); AXI_BURST_INCR, AXI_RESP_OKAY, BOUNDARY_4K.
//  - Sub-module dma_sync_fifo (WIDTH, DEPTH; push/pop/head/count/flush, show-ahead).
//  - Burst-length calc: combinational function in dma_pkg.
// TESTING
//  1. NUM_ACCS=196, dst 0x1000_0000, slave always ready
//     -> bursts awlen 15 @0x1000_0000 and 8 @0x1000_0080; 25 beats in order; done, err=0.
//  2. dst 0x1000_0FC0 -> awlen 7 @0x1000_0FC0, 15 @0x1000_1000, 0 @0x1000_1080; no burst crosses 4 KB.
//  3. Random wready (30% low) and awready delays
//     -> data matches accumulator model, rd_en stalls at FIFO_DEPTH, no VALID drop.
//  4. bresp=2'b10 on first burst -> no second AW, DRAIN completes, done with err=1.
//  5. dst 0 -> done next cycle, err=0. dst 0x1000_0004 -> done, err=1. Neither issues AXI activity.
//  6. rst_n low during W beat 5 -> next cycle all outputs 0, IDLE. New start completes normally.

Source files
------------

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types, AXI constants and burst sizing for the output write DMA
//
// Purpose: state encoding of the write DMA FSM, AXI field constants and the
//          combinational burst-length calculation used when issuing AW.
// Contents:
//   dma_wr_state_t   3-bit state code, ST_* constants
//   AXI_BURST_INCR   AWBURST encoding for INCR
//   AXI_RESP_OKAY    BRESP encoding for OKAY
//   BOUNDARY_4K      AXI burst boundary in bytes
//   calc_burst_len   min(max_burst, words_left, words remaining before 4 KB line)

package dma_pkg;

    typedef logic [2:0] dma_wr_state_t;

    localparam dma_wr_state_t ST_IDLE       = 3'd0;
    localparam dma_wr_state_t ST_WAIT_READY = 3'd1;
    localparam dma_wr_state_t ST_AW         = 3'd2;
    localparam dma_wr_state_t ST_W          = 3'd3;
    localparam dma_wr_state_t ST_B          = 3'd4;
    localparam dma_wr_state_t ST_DRAIN      = 3'd5;
    localparam dma_wr_state_t ST_DONE       = 3'd6;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         BOUNDARY_4K    = 4096;

    // The address is always word aligned, so the room left before the 4 KB line
    // is at least one word and the result is never zero while words remain.
    function automatic logic [8:0] calc_burst_len(
        input logic [11:0] addr_lo,
        input logic [15:0] words_left,
        input logic [8:0]  max_burst,
        input int          bpw_log2
    );
        logic [15:0] room;
        logic [15:0] len;
        room = (16'(BOUNDARY_4K) - {4'd0, addr_lo}) >> bpw_log2;
        len  = {7'd0, max_burst};
        if (words_left < len) begin
            len = words_left;
        end
        if (room < len) begin
            len = room;
        end
        return len[8:0];
    endfunction

endpackage

// File: rtl/dma_sync_fifo.sv
// rtl/dma_sync_fifo.sv - show-ahead synchronous FIFO with flush
//
// Purpose: prefetch buffer between the accumulator read port and the AXI W channel.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   push         write push_data (ignored when full)
//   push_data    WIDTH-bit write data
//   pop          drop the head entry (ignored when empty)
//   flush        empty the FIFO this cycle
//   head         current head entry (valid when !empty)
//   count        number of stored entries
//   empty, full  status flags

module dma_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
            end
        end
    end

endmodule

// File: rtl/out_wr_dma.sv
// rtl/out_wr_dma.sv - output write DMA: accumulator results to DDR over AXI4 INCR bursts
//
// Purpose: streams NUM_WORDS words from the output accumulator to dst_addr in
//          bursts of up to MAX_BURST beats that never cross a 4 KB line. A read
//          engine prefetches into a credit-gated FIFO while AW/W run.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   start, dst_addr            transfer trigger and DDR destination
//   done, err, busy            completion pulse, error (valid with done), in progress
//   accum_rd_en/addr/data      accumulator read port, data RD_LAT cycles after en
//   accum_ready                inactive accumulator bank is ready to read
//   m_axi_aw*, m_axi_w*, m_axi_b*   AXI4 write address, data and response channels

module out_wr_dma
    import dma_pkg::*;
#(
    parameter int AXI_ADDR_W  = 32,
    parameter int AXI_DATA_W  = 64,
    parameter int AXI_ID_W    = 4,
    parameter int BRAM_ADDR_W = 10,
    parameter int NUM_ACCS    = 196,
    parameter int MAX_BURST   = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int RD_LAT      = 2,
    parameter int STREAM_ID   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [AXI_ADDR_W-1:0]   dst_addr,
    output logic                    done,
    output logic                    err,
    output logic                    busy,
    output logic                    accum_rd_en,
    output logic [BRAM_ADDR_W-1:0]  accum_rd_addr,
    input  logic [AXI_DATA_W-1:0]   accum_rd_data,
    input  logic                    accum_ready,
    output logic [AXI_ID_W-1:0]     m_axi_awid,
    output logic [AXI_ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [AXI_DATA_W-1:0]   m_axi_wdata,
    output logic [AXI_DATA_W/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [AXI_ID_W-1:0]     m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready
);

    localparam int BPW       = AXI_DATA_W / 8;
    localparam int BPW_LOG2  = $clog2(BPW);
    localparam int NUM_WORDS = (NUM_ACCS + BPW - 1) / BPW;
    localparam int CNT_W     = $clog2(NUM_WORDS + 1);
    localparam int FCNT_W    = $clog2(FIFO_DEPTH + 1);

    dma_wr_state_t         state_q, state_d;
    logic [AXI_ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      words_left_q, words_left_d;
    logic [CNT_W-1:0]      rd_idx_q, rd_idx_d;
    logic                  rd_active_q, rd_active_d;
    logic [8:0]            len_q, len_d;
    logic [8:0]            beat_q, beat_d;
    logic                  err_q, err_d;
    logic [RD_LAT-1:0]     sr_q, sr_d;

    logic [8:0]            burst_len;
    logic [8:0]            burst_len_m1;
    logic [15:0]           in_flight;
    logic [15:0]           occupancy;
    logic                  rd_issue;
    logic [31:0]           rd_addr_full;
    logic                  w_hs;
    logic                  last_beat;

    logic [AXI_DATA_W-1:0] fifo_head;
    logic [FCNT_W-1:0]     fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  fifo_flush;
    logic                  unused_bits;

    dma_sync_fifo #(
        .WIDTH (AXI_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (sr_q[RD_LAT-1]),
        .push_data (accum_rd_data),
        .pop       (w_hs),
        .flush     (fifo_flush),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Words already requested from the accumulator but not yet in the FIFO.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            in_flight = in_flight + 16'(sr_q[i]);
        end
    end

    // Credit gate: a read is only issued if its data is guaranteed a FIFO slot,
    // counting reads still in the accumulator pipeline.
    assign occupancy    = 16'(fifo_count) + in_flight;
    assign rd_issue     = rd_active_q && (rd_idx_q < CNT_W'(NUM_WORDS)) &&
                          (occupancy < 16'(FIFO_DEPTH));
    assign rd_addr_full = 32'(rd_idx_q) << BPW_LOG2;

    assign burst_len    = calc_burst_len(addr_q[11:0], 16'(words_left_q), 9'(MAX_BURST), BPW_LOG2);
    assign burst_len_m1 = burst_len - 9'd1;
    assign last_beat    = (beat_q == len_q - 9'd1);
    assign w_hs         = m_axi_wvalid && m_axi_wready;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        words_left_d = words_left_q;
        rd_idx_d     = rd_idx_q;
        rd_active_d  = rd_active_q;
        len_d        = len_q;
        beat_d       = beat_q;
        err_d        = err_q;
        fifo_flush   = 1'b0;
        sr_d         = sr_q << 1;
        sr_d[0]      = rd_issue;

        if (rd_issue) begin
            rd_idx_d = rd_idx_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (dst_addr == '0) begin
                        err_d   = 1'b0;
                        state_d = ST_DONE;
                    end else if ((dst_addr & AXI_ADDR_W'(BPW - 1)) != '0) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        err_d        = 1'b0;
                        addr_d       = dst_addr;
                        words_left_d = CNT_W'(NUM_WORDS);
                        state_d      = ST_WAIT_READY;
                    end
                end
            end
            ST_WAIT_READY: begin
                if (accum_ready) begin
                    rd_active_d = 1'b1;
                    rd_idx_d    = '0;
                    state_d     = ST_AW;
                end
            end
            ST_AW: begin
                if (m_axi_awready) begin
                    len_d   = burst_len;
                    beat_d  = '0;
                    state_d = ST_W;
                end
            end
            ST_W: begin
                if (w_hs) begin
                    beat_d = beat_q + 9'd1;
                    if (last_beat) begin
                        state_d = ST_B;
                    end
                end
            end
            ST_B: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != AXI_RESP_OKAY) begin
                        err_d       = 1'b1;
                        rd_active_d = 1'b0;
                        state_d     = ST_DRAIN;
                    end else begin
                        addr_d       = addr_q + (AXI_ADDR_W'(len_q) << BPW_LOG2);
                        words_left_d = words_left_q - CNT_W'(len_q);
                        if (16'(words_left_q) == 16'(len_q)) begin
                            rd_active_d = 1'b0;
                            state_d     = ST_DONE;
                        end else begin
                            state_d = ST_AW;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                // Reads already in the accumulator pipeline must land before the
                // flush, otherwise they would reappear in the next transfer.
                rd_active_d = 1'b0;
                if (in_flight == '0) begin
                    fifo_flush = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                rd_active_d = 1'b0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            words_left_q <= '0;
            rd_idx_q     <= '0;
            rd_active_q  <= 1'b0;
            len_q        <= '0;
            beat_q       <= '0;
            err_q        <= 1'b0;
            sr_q         <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            words_left_q <= words_left_d;
            rd_idx_q     <= rd_idx_d;
            rd_active_q  <= rd_active_d;
            len_q        <= len_d;
            beat_q       <= beat_d;
            err_q        <= err_d;
            sr_q         <= sr_d;
        end
    end

    assign done          = (state_q == ST_DONE);
    assign err           = done && err_q;
    assign busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);

    assign accum_rd_en   = rd_issue;
    assign accum_rd_addr = rd_addr_full[BRAM_ADDR_W-1:0];

    // Channel payloads are zeroed whenever VALID is low so idle outputs are quiet.
    assign m_axi_awvalid = (state_q == ST_AW);
    assign m_axi_awid    = m_axi_awvalid ? AXI_ID_W'(STREAM_ID) : '0;
    assign m_axi_awaddr  = m_axi_awvalid ? addr_q : '0;
    assign m_axi_awlen   = m_axi_awvalid ? burst_len_m1[7:0] : '0;
    assign m_axi_awsize  = m_axi_awvalid ? 3'(BPW_LOG2) : '0;
    assign m_axi_awburst = m_axi_awvalid ? AXI_BURST_INCR : '0;

    assign m_axi_wvalid  = (state_q == ST_W) && !fifo_empty;
    assign m_axi_wdata   = m_axi_wvalid ? fifo_head : '0;
    assign m_axi_wstrb   = m_axi_wvalid ? '1 : '0;
    assign m_axi_wlast   = m_axi_wvalid && last_beat;

    assign m_axi_bready  = (state_q == ST_B);

    assign unused_bits   = ^{m_axi_bid, fifo_full, burst_len_m1[8], rd_addr_full[31:BRAM_ADDR_W]};

endmodule

// File: tb/tb_out_wr_dma.sv
// tb/tb_out_wr_dma.sv - directed self-checking bench for out_wr_dma

module tb_out_wr_dma;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dst_addr = '0;
    logic        done, err, busy;
    logic        accum_rd_en;
    logic [9:0]  accum_rd_addr;
    logic [63:0] accum_rd_data = '0;
    logic        accum_ready = 1'b0;
    logic [3:0]  m_axi_awid;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b1;
    logic [63:0] m_axi_wdata;
    logic [7:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_wvalid;
    logic        m_axi_wready = 1'b1;
    logic [3:0]  m_axi_bid = '0;
    logic [1:0]  m_axi_bresp = 2'b00;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;

    always #5 clk = ~clk;

    out_wr_dma dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .dst_addr      (dst_addr),
        .done          (done),
        .err           (err),
        .busy          (busy),
        .accum_rd_en   (accum_rd_en),
        .accum_rd_addr (accum_rd_addr),
        .accum_rd_data (accum_rd_data),
        .accum_ready   (accum_ready),
        .m_axi_awid    (m_axi_awid),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awlen   (m_axi_awlen),
        .m_axi_awsize  (m_axi_awsize),
        .m_axi_awburst (m_axi_awburst),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wlast   (m_axi_wlast),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bid     (m_axi_bid),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] word_data(input int w);
        return {16'hC0DE, 16'(w), ~16'(w), 16'(w * 3)};
    endfunction

    // Slave / memory model state
    int          p0 = 0, p1 = 0;
    int          aw_cnt = 0, w_beats = 0, bib = 0, cur_len = 0, rd_cnt = 0, peak = 0, b_cnt = 0;
    int          aw_hold = 0;
    logic [31:0] aw_addr_log [8];
    logic [7:0]  aw_len_log [8];
    bit          rnd = 1'b0, bresp_err_first = 1'b0;
    bit          pend_b = 1'b0, b_hs = 1'b0, aw_wait_prev = 1'b0, w_wait_prev = 1'b0;
    logic [31:0] prev_awaddr;
    logic [7:0]  prev_awlen;
    logic [63:0] prev_wdata;

    // Inputs change at the falling edge; the handshakes recorded here are the
    // ones the DUT sees at the following rising edge.
    always @(negedge clk) begin
        accum_rd_data = word_data(p1);
        p1 = p0;
        p0 = int'(accum_rd_addr) >> 3;
        if (!rst_n) begin
            aw_wait_prev = 1'b0;
            w_wait_prev  = 1'b0;
            pend_b       = 1'b0;
            b_hs         = 1'b0;
            m_axi_bvalid = 1'b0;
        end else begin
            if (b_hs) begin
                m_axi_bvalid = 1'b0;
                b_hs = 1'b0;
            end
            if (pend_b) begin
                m_axi_bvalid = 1'b1;
                m_axi_bresp  = (bresp_err_first && b_cnt == 0) ? 2'b10 : 2'b00;
                pend_b = 1'b0;
            end
            if (aw_hold > 0 && m_axi_awvalid) begin
                m_axi_awready = 1'b0;
                aw_hold--;
            end else begin
                m_axi_awready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            m_axi_wready = rnd ? ($urandom_range(0, 9) >= 3) : 1'b1;

            if (aw_wait_prev) begin
                check("aw_valid_held", m_axi_awvalid, 1);
                check("aw_addr_stable", m_axi_awaddr, prev_awaddr);
                check("aw_len_stable", m_axi_awlen, prev_awlen);
            end
            if (w_wait_prev) begin
                check("w_valid_held", m_axi_wvalid, 1);
                check("w_data_stable", m_axi_wdata, prev_wdata);
            end
            if (m_axi_awvalid && m_axi_awready) begin
                check("awsize", m_axi_awsize, 3);
                check("awburst", m_axi_awburst, 1);
                check("awid", m_axi_awid, 2);
                check("aw_4k", (int'(m_axi_awaddr[11:0]) + (int'(m_axi_awlen) + 1) * 8) <= 4096, 1);
                if (aw_cnt < 8) begin
                    aw_addr_log[aw_cnt] = m_axi_awaddr;
                    aw_len_log[aw_cnt]  = m_axi_awlen;
                end
                aw_cnt++;
                cur_len = int'(m_axi_awlen);
                bib = 0;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                check("wdata", m_axi_wdata, word_data(w_beats));
                check("wlast", m_axi_wlast, bib == cur_len);
                check("wstrb", m_axi_wstrb, 8'hFF);
                if (bib == cur_len) pend_b = 1'b1;
                w_beats++;
                bib++;
            end
            if (m_axi_bvalid && m_axi_bready) begin
                b_hs = 1'b1;
                b_cnt++;
            end
            if (accum_rd_en) rd_cnt++;
            if (rd_cnt - w_beats > peak) peak = rd_cnt - w_beats;
            aw_wait_prev = m_axi_awvalid && !m_axi_awready;
            w_wait_prev  = m_axi_wvalid && !m_axi_wready;
            prev_awaddr  = m_axi_awaddr;
            prev_awlen   = m_axi_awlen;
            prev_wdata   = m_axi_wdata;
        end
    end

    task automatic clear_log();
        aw_cnt = 0; w_beats = 0; bib = 0; cur_len = 0; rd_cnt = 0; peak = 0; b_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            aw_addr_log[i] = '0;
            aw_len_log[i]  = '0;
        end
    endtask

    // Called at posedge+1. Returns err sampled with done and cycles from start to done.
    task automatic run_xfer(input logic [31:0] a, input int rdy_delay, output logic got_err, output int cyc);
        clear_log();
        accum_ready = (rdy_delay == 0);
        dst_addr = a;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dst_addr = '0;
        cyc = 0;
        while (!done && cyc < 3000) begin
            if (cyc == 1 && rdy_delay > 1) begin
                check("wait_ready_busy", busy, 1);
                check("wait_ready_no_rd", accum_rd_en, 0);
            end
            if (cyc == rdy_delay) accum_ready = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        check("done_seen", done, 1);
        got_err = err;
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rd_en"}, accum_rd_en, 0);
        check({tag, "_awvalid"}, m_axi_awvalid, 0);
        check({tag, "_awaddr"}, m_axi_awaddr, 0);
        check({tag, "_awlen"}, m_axi_awlen, 0);
        check({tag, "_wvalid"}, m_axi_wvalid, 0);
        check({tag, "_wdata"}, m_axi_wdata, 0);
        check({tag, "_wlast"}, m_axi_wlast, 0);
        check({tag, "_bready"}, m_axi_bready, 0);
    endtask

    logic e;
    int   c;
    int   guard;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: aligned 4 KB-interior destination, accumulator ready after a delay
        run_xfer(32'h1000_0000, 3, e, c);
        check("t1_err", e, 0);
        check("t1_aw_cnt", aw_cnt, 2);
        check("t1_aw0_addr", aw_addr_log[0], 32'h1000_0000);
        check("t1_aw0_len", aw_len_log[0], 15);
        check("t1_aw1_addr", aw_addr_log[1], 32'h1000_0080);
        check("t1_aw1_len", aw_len_log[1], 8);
        check("t1_beats", w_beats, 25);
        check("t1_reads", rd_cnt, 25);

        // 2: destination 64 bytes below a 4 KB line
        run_xfer(32'h1000_0FC0, 0, e, c);
        check("t2_err", e, 0);
        check("t2_aw_cnt", aw_cnt, 3);
        check("t2_aw0_addr", aw_addr_log[0], 32'h1000_0FC0);
        check("t2_aw0_len", aw_len_log[0], 7);
        check("t2_aw1_addr", aw_addr_log[1], 32'h1000_1000);
        check("t2_aw1_len", aw_len_log[1], 15);
        check("t2_aw2_addr", aw_addr_log[2], 32'h1000_1080);
        check("t2_aw2_len", aw_len_log[2], 0);
        check("t2_beats", w_beats, 25);

        // 3: random back-pressure, first AW held long enough to fill the FIFO
        rnd = 1'b1;
        aw_hold = 12;
        run_xfer(32'h2000_0000, 0, e, c);
        rnd = 1'b0;
        check("t3_err", e, 0);
        check("t3_aw_cnt", aw_cnt, 2);
        check("t3_aw1_addr", aw_addr_log[1], 32'h2000_0080);
        check("t3_beats", w_beats, 25);
        check("t3_reads", rd_cnt, 25);
        check("t3_fifo_peak", peak, 8);

        // 4: SLVERR on the first burst
        bresp_err_first = 1'b1;
        run_xfer(32'h1000_0000, 0, e, c);
        bresp_err_first = 1'b0;
        check("t4_err", e, 1);
        check("t4_aw_cnt", aw_cnt, 1);
        check("t4_beats", w_beats, 16);
        check("t4_peak_bound", peak <= 8, 1);

        // 5: null and misaligned destinations complete immediately without traffic
        run_xfer(32'h0000_0000, 0, e, c);
        check("t5a_cycles", c, 0);
        check("t5a_err", e, 0);
        check("t5a_aw_cnt", aw_cnt, 0);
        check("t5a_reads", rd_cnt, 0);
        run_xfer(32'h1000_0004, 0, e, c);
        check("t5b_cycles", c, 0);
        check("t5b_err", e, 1);
        check("t5b_aw_cnt", aw_cnt, 0);
        check("t5b_reads", rd_cnt, 0);

        // 6: reset in the middle of the W phase, then a clean transfer
        clear_log();
        accum_ready = 1'b1;
        dst_addr = 32'h1000_0000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        while (w_beats < 5 && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        check("t6_reach_beat5", w_beats, 5);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("t6_reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_xfer(32'h1000_0000, 0, e, c);
        check("t6_err", e, 0);
        check("t6_aw_cnt", aw_cnt, 2);
        check("t6_aw1_len", aw_len_log[1], 8);
        check("t6_beats", w_beats, 25);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
